mem_port_arbiter: RTL

Single-port arbiter between the instruction-fetch stage and the MEM-stage load/store unit for the unified byte-addressed instruction/data memory of the pipelined RISC-V core. Each cycle it grants the memory port to at most one requester and drives the memory's read/write/funct3/address/data inputs. It captures the combinational read data into a registered per-requester response and generates the stall signals the hazard unit uses to freeze the losing stage. A bounded-starvation counter keeps fetch from being locked out by back-to-back data accesses.

---
 rtl/mem_port_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Grants the shared instruction/data memory port to fetch or load/store; grant/stall same cycle, response registered one cycle later.
// Data wins contention until fetch has lost STARVE_MAX times in a row; the loser is stalled and must hold its request.
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_stall,
   output logic              if_valid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_f3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_stall,
   output logic              d_valid,
   output logic [31:0]       d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_f3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   logic [3:0] starve_cnt;
   logic       starved;

   assign starved = (starve_cnt == 4'(STARVE_MAX));

   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (if_req && d_req) begin
            if (starved) if_gnt = 1'b1;
            else         d_gnt  = 1'b1;
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   assign if_stall  = if_req & ~if_gnt;
   assign d_stall   = d_req & ~d_gnt;
   assign mem_wdata = d_wdata;

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_f3    = 3'b000;
      mem_addr  = '0;
      if (if_gnt) begin
         mem_read = 1'b1;
         mem_f3   = 3'b010;
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_read  = ~d_we;
         mem_write = d_we;
         mem_f3    = d_f3;
         mem_addr  = d_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= 4'd0;
         if_valid   <= 1'b0;
         d_valid    <= 1'b0;
         if_rdata   <= 32'd0;
         d_rdata    <= 32'd0;
      end else begin
         if_valid <= if_gnt;
         d_valid  <= d_gnt;
         if (if_gnt) if_rdata <= mem_rdata;
         if (d_gnt)  d_rdata  <= d_we ? 32'd0 : mem_rdata;
         // Counts consecutive data wins while fetch waits.
         if (if_gnt || !if_req)
            starve_cnt <= 4'd0;
         else if (d_gnt && !starved)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule
